// File: rtl/md_div_ctrl.sv
// Multi-cycle divide sequencer for DIV/DIVU/REM/REMU in the EX stage.
// Radix-2 restoring divide on magnitudes, followed by a sign-fix cycle.
module md_div_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dsr_q, dsr_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              negQ_q, negQ_d;
  logic              negR_q, negR_d;
  logic              isRem_q, isRem_d;

  logic              isSigned;
  logic              accept;
  logic [XLEN:0]     remWide;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   quoFixed;
  logic [XLEN-1:0]   remFixed;

  assign isSigned = ~funct3_i[0];
  assign accept   = start_i & funct3_i[2] & ~flush_i;

  // One extra bit on the partial remainder so the trial subtract never drops a carry.
  assign remWide  = {rem_q, dvd_q[XLEN-1]};
  assign diff     = remWide - {1'b0, dsr_q};
  assign quoFixed = negQ_q ? -quo_q : quo_q;
  assign remFixed = negR_q ? -rem_q : rem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      isRem_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      isRem_q  <= isRem_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    isRem_d  = isRem_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          isRem_d = funct3_i[1];
          negQ_d  = isSigned & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
          negR_d  = isSigned & rs1_i[XLEN-1];
          dvd_d   = (isSigned && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
          dsr_d   = (isSigned && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          // Divide-by-zero and signed overflow skip the loop with architectural results.
          if (rs2_i == '0) begin
            result_d = funct3_i[1] ? rs1_i : '1;
            state_d  = DONE;
          end else if (isSigned && rs1_i == MIN_INT && rs2_i == '1) begin
            result_d = funct3_i[1] ? '0 : MIN_INT;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = remWide[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = isRem_q ? remFixed : quoFixed;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush_i) begin
      state_d = IDLE;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule
